// File: rtl/alu_result_buffer_pkg.sv
// Shared CPU constants for the ALU result path: default datapath width, opsel codes,
// and the flag bundle that is stored with each buffered result.
package alu_result_buffer_pkg;

    localparam int WIDTH_DEFAULT = 24;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_LESS = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generation for one ALU result, evaluated at the buffer write side.
module alu_flag_gen
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_result,
    input  logic [2:0]       i_opsel,
    input  logic             i_cout,
    input  logic             i_a_msb,
    input  logic             i_b_msb,
    output flags_t           o_flags
);

    logic w_is_add;

    assign w_is_add = (i_opsel == OP_ADD);

    always_comb begin
        o_flags       = '0;
        o_flags.zero  = (i_result == '0);
        o_flags.neg   = i_result[WIDTH-1];
        // Carry and signed overflow only mean something for the adder path.
        o_flags.carry = w_is_add && i_cout;
        o_flags.ovf   = w_is_add && (i_a_msb == i_b_msb) && (i_result[WIDTH-1] != i_a_msb);
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer between the ALU result selectors and writeback; flags are
// computed on push and travel with the result, plus a sticky overflow indicator.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_opsel,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [WIDTH-1:0] r_mem_result [DEPTH];
    flags_t           r_mem_flags  [DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_hold_result;
    flags_t           r_hold_flags;
    logic             r_ovf_sticky;

    flags_t           w_flags;
    flags_t           w_out_flags;
    logic             w_push;
    logic             w_pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .i_result (in_result),
        .i_opsel  (in_opsel),
        .i_cout   (in_cout),
        .i_a_msb  (in_a_msb),
        .i_b_msb  (in_b_msb),
        .o_flags  (w_flags)
    );

    assign in_ready  = (r_count < FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_result[i] <= '0;
                r_mem_flags[i]  <= '0;
            end
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_hold_result <= '0;
            r_hold_flags  <= '0;
            r_ovf_sticky  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_result[r_wr_ptr] <= in_result;
                r_mem_flags[r_wr_ptr]  <= w_flags;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            // Capture the departing head so the outputs stay put once the buffer drains.
            if (w_pop) begin
                r_hold_result <= r_mem_result[r_rd_ptr];
                r_hold_flags  <= r_mem_flags[r_rd_ptr];
                r_rd_ptr      <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_flags.ovf) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        out_result  = r_hold_result;
        w_out_flags = r_hold_flags;
        if (out_valid) begin
            out_result  = r_mem_result[r_rd_ptr];
            w_out_flags = r_mem_flags[r_rd_ptr];
        end
    end

    assign out_zero   = w_out_flags.zero;
    assign out_neg    = w_out_flags.neg;
    assign out_carry  = w_out_flags.carry;
    assign out_ovf    = w_out_flags.ovf;
    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 24, datapath width of the ALU result.
REQ-002 Parameter DEPTH, fixed at 2, number of buffer entries; other values are not supported.
REQ-003 Port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, upstream ALU result is present.
REQ-006 Port in_ready, output, 1, block can accept an entry this cycle.
REQ-007 Port in_result, input, WIDTH, assembled output of the per-bit 8-to-1 result selectors.
REQ-008 Port in_opsel, input, 3, selector code driven to the result selectors.
  - 000 and, 001 or, 010 add, 011 less, 100 xor, 101-111 spare.
REQ-009 Port in_cout, input, 1, adder carry out of the MSB slice.
REQ-010 Port in_a_msb / in_b_msb, input, 1 each, operand sign bits.
REQ-011 Port out_valid, output, 1, head entry is valid.
REQ-012 Port out_ready, input, 1, downstream (writeback) accepts the head entry.
REQ-013 Port out_result, output, WIDTH, head entry result.
REQ-014 Port out_zero, out_neg, out_carry, out_ovf, output, 1 each, head entry flags.
REQ-015 Port ovf_sticky, output, 1, accumulated overflow indicator.
REQ-016 Port clr_sticky, input, 1, clears ovf_sticky.

Function
REQ-017 The block SHALL push when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-018 The block SHALL compute flags at push time and store them with the result.
  - zero = (in_result == 0)
  - neg = in_result[WIDTH-1]
  - carry = in_cout if in_opsel == 010, else 0
  - ovf = (in_a_msb == in_b_msb) && (in_result[WIDTH-1] != in_a_msb) if in_opsel == 010, else 0
REQ-019 The block SHALL hold an occupancy count of 0, 1 or 2, with 1-bit read and write pointers that wrap 1 -> 0.
REQ-020 in_ready SHALL equal (count < 2); it depends only on registered state.
REQ-021 out_valid SHALL equal (count > 0).
  - out_result and flags are driven from the head entry.
  - Latency from push to out_valid is 1 cycle.
REQ-022 On a simultaneous push and pop with count 1, count SHALL stay 1 and both pointers SHALL advance.
REQ-023 When full (count 2), push SHALL be blocked by in_ready = 0 and pop SHALL proceed normally.
REQ-024 When empty, a pop request SHALL be ignored and outputs SHALL keep their last value while out_valid = 0.
REQ-025 The head entry and its flags SHALL remain stable while out_valid && !out_ready.
REQ-026 ovf_sticky SHALL set on any push whose computed ovf = 1 and clear on clr_sticky.
  - Set has priority over clear in the same cycle.
REQ-027 Spare opsel codes SHALL be stored unchanged, with carry and ovf forced to 0.

Reset
REQ-028 While Reset = 0, the block SHALL asynchronously clear count, both pointers and ovf_sticky.
  - Resulting outputs: in_ready = 1, out_valid = 0, out_result = 0, all flags 0.
REQ-029 A reset asserted mid-operation SHALL discard all buffered entries with no partial pop.
REQ-030 The first push SHALL be possible on the first rising edge after Reset deasserts.

Structure
REQ-031 The opsel encodings (AND, OR, ADD, LESS, XOR) and the default WIDTH SHALL be defined as constants in the shared CPU constants package.
REQ-032 Flag computation SHALL be a combinational sub-module named alu_flag_gen, instantiated once at the write side.
REQ-033 The storage array, the pointers and the count SHALL be in the top module, with no other sub-modules.

Verification
REQ-034 Reset, then push add 0x7FFFFF+0x000001 (result 0x800000, a_msb = 0, b_msb = 0, cout = 0) -> next cycle out_valid = 1, neg = 1, ovf = 1, zero = 0, ovf_sticky = 1.
REQ-035 Push and 000 with result 0x000000 and cout = 1 -> zero = 1, carry = 0, ovf = 0.
REQ-036 Hold out_ready = 0 and push 3 entries back-to-back -> in_ready drops after 2 accepts, the third is held upstream, and the head stays equal to the first entry.
REQ-037 With count 1, push and pop in the same cycle for 10 cycles -> count stays 1 and the output sequence equals the input sequence delayed by 1.
REQ-038 Assert clr_sticky in the same cycle as an overflowing push -> ovf_sticky = 1; clr_sticky alone next cycle -> ovf_sticky = 0.
REQ-039 Assert Reset with count 2 -> out_valid = 0 and in_ready = 1 immediately, before the next Clock edge.
